// File: rtl/w7_loader_if.sv
// Weight-stream handshake plus the sixteen bank write ports of w7_loader.
// The master modport is the weight source side; the slave modport is the loader.
interface w7_loader_if;
    logic              start;
    logic              finish;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              in_ready;
    logic              cksum_err;

    logic [3:0]        w0_waddr;   logic signed [7:0] w0_wdata;   logic w0_we;
    logic [3:0]        w1_waddr;   logic signed [7:0] w1_wdata;   logic w1_we;
    logic [3:0]        w2_waddr;   logic signed [7:0] w2_wdata;   logic w2_we;
    logic [3:0]        w3_waddr;   logic signed [7:0] w3_wdata;   logic w3_we;
    logic [3:0]        w4_waddr;   logic signed [7:0] w4_wdata;   logic w4_we;
    logic [3:0]        w5_waddr;   logic signed [7:0] w5_wdata;   logic w5_we;
    logic [3:0]        w6_waddr;   logic signed [7:0] w6_wdata;   logic w6_we;
    logic [3:0]        w7_waddr;   logic signed [7:0] w7_wdata;   logic w7_we;
    logic [3:0]        w8_waddr;   logic signed [7:0] w8_wdata;   logic w8_we;
    logic [3:0]        w9_waddr;   logic signed [7:0] w9_wdata;   logic w9_we;
    logic [3:0]        w10_waddr;  logic signed [7:0] w10_wdata;  logic w10_we;
    logic [3:0]        w11_waddr;  logic signed [7:0] w11_wdata;  logic w11_we;
    logic [3:0]        w12_waddr;  logic signed [7:0] w12_wdata;  logic w12_we;
    logic [3:0]        w13_waddr;  logic signed [7:0] w13_wdata;  logic w13_we;
    logic [3:0]        w14_waddr;  logic signed [7:0] w14_wdata;  logic w14_we;
    logic [3:0]        w15_waddr;  logic signed [7:0] w15_wdata;  logic w15_we;

    modport master (
        output start, in_valid, in_data,
        input  finish, in_ready, cksum_err,
        input  w0_waddr,  w0_wdata,  w0_we,
        input  w1_waddr,  w1_wdata,  w1_we,
        input  w2_waddr,  w2_wdata,  w2_we,
        input  w3_waddr,  w3_wdata,  w3_we,
        input  w4_waddr,  w4_wdata,  w4_we,
        input  w5_waddr,  w5_wdata,  w5_we,
        input  w6_waddr,  w6_wdata,  w6_we,
        input  w7_waddr,  w7_wdata,  w7_we,
        input  w8_waddr,  w8_wdata,  w8_we,
        input  w9_waddr,  w9_wdata,  w9_we,
        input  w10_waddr, w10_wdata, w10_we,
        input  w11_waddr, w11_wdata, w11_we,
        input  w12_waddr, w12_wdata, w12_we,
        input  w13_waddr, w13_wdata, w13_we,
        input  w14_waddr, w14_wdata, w14_we,
        input  w15_waddr, w15_wdata, w15_we
    );

    modport slave (
        input  start, in_valid, in_data,
        output finish, in_ready, cksum_err,
        output w0_waddr,  w0_wdata,  w0_we,
        output w1_waddr,  w1_wdata,  w1_we,
        output w2_waddr,  w2_wdata,  w2_we,
        output w3_waddr,  w3_wdata,  w3_we,
        output w4_waddr,  w4_wdata,  w4_we,
        output w5_waddr,  w5_wdata,  w5_we,
        output w6_waddr,  w6_wdata,  w6_we,
        output w7_waddr,  w7_wdata,  w7_we,
        output w8_waddr,  w8_wdata,  w8_we,
        output w9_waddr,  w9_wdata,  w9_we,
        output w10_waddr, w10_wdata, w10_we,
        output w11_waddr, w11_wdata, w11_we,
        output w12_waddr, w12_wdata, w12_we,
        output w13_waddr, w13_wdata, w13_we,
        output w14_waddr, w14_wdata, w14_we,
        output w15_waddr, w15_wdata, w15_we
    );
endinterface

// File: rtl/w7_loader.sv
// w7_loader: writes a 256-byte weight stream bank-interleaved into 16 banks x 16 entries.
// Optional trailing modulo-256 checksum byte when W7_LOADER_CKSUM_EN is defined.
module w7_loader (
    input  logic         clk,
    input  logic         xrst,
    w7_loader_if.slave   bus
);

`ifdef W7_LOADER_CKSUM_EN
    localparam int               CNT_W    = 9;
    localparam logic [CNT_W-1:0] LAST_IDX = 9'd256;
`else
    localparam int               CNT_W    = 8;
    localparam logic [CNT_W-1:0] LAST_IDX = 8'd255;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, FIN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       waddr_q, waddr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [15:0]      we_q,    we_d;

    logic in_ready;
    logic finish;
    logic accept;
    logic start_acc;
    logic ck_byte;

    assign accept    = bus.in_valid & in_ready;
    assign start_acc = (state_q == IDLE) & bus.start;

`ifdef W7_LOADER_CKSUM_EN
    assign ck_byte = cnt_q[CNT_W-1];
`else
    assign ck_byte = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: each always_comb assigns defaults first so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (accept && (cnt_q == LAST_IDX)) state_d = FLUSH;
            FLUSH:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        finish   = 1'b0;
        case (state_q)
            LOAD:    in_ready = 1'b1;
            FIN:     finish   = 1'b1;
            default: ;
        endcase
    end

    // Byte k lands in bank k[3:0] at entry k[7:4]; the checksum byte is never written.
    always_comb begin
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = '0;
        if (start_acc) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            if (!ck_byte) begin
                waddr_d = cnt_q[7:4];
                wdata_d = bus.in_data;
                we_d    = 16'h0001 << cnt_q[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

`ifdef W7_LOADER_CKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       mism_q, mism_d;
    logic       cksum_err_q, cksum_err_d;

    // The compare result is parked until FLUSH so the flag rises together with finish.
    always_comb begin
        sum_d       = sum_q;
        mism_d      = mism_q;
        cksum_err_d = cksum_err_q;
        if (start_acc) begin
            sum_d       = '0;
            mism_d      = 1'b0;
            cksum_err_d = 1'b0;
        end else if (accept) begin
            if (ck_byte) mism_d = (bus.in_data != sum_q);
            else         sum_d  = sum_q + bus.in_data;
        end
        if (state_q == FLUSH) cksum_err_d = mism_q;
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            sum_q       <= '0;
            mism_q      <= 1'b0;
            cksum_err_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            mism_q      <= mism_d;
            cksum_err_q <= cksum_err_d;
        end
    end

    assign bus.cksum_err = cksum_err_q;
`else
    assign bus.cksum_err = 1'b0;
`endif

    assign bus.in_ready = in_ready;
    assign bus.finish   = finish;

    assign bus.w0_waddr  = waddr_q;  assign bus.w0_wdata  = wdata_q;  assign bus.w0_we  = we_q[0];
    assign bus.w1_waddr  = waddr_q;  assign bus.w1_wdata  = wdata_q;  assign bus.w1_we  = we_q[1];
    assign bus.w2_waddr  = waddr_q;  assign bus.w2_wdata  = wdata_q;  assign bus.w2_we  = we_q[2];
    assign bus.w3_waddr  = waddr_q;  assign bus.w3_wdata  = wdata_q;  assign bus.w3_we  = we_q[3];
    assign bus.w4_waddr  = waddr_q;  assign bus.w4_wdata  = wdata_q;  assign bus.w4_we  = we_q[4];
    assign bus.w5_waddr  = waddr_q;  assign bus.w5_wdata  = wdata_q;  assign bus.w5_we  = we_q[5];
    assign bus.w6_waddr  = waddr_q;  assign bus.w6_wdata  = wdata_q;  assign bus.w6_we  = we_q[6];
    assign bus.w7_waddr  = waddr_q;  assign bus.w7_wdata  = wdata_q;  assign bus.w7_we  = we_q[7];
    assign bus.w8_waddr  = waddr_q;  assign bus.w8_wdata  = wdata_q;  assign bus.w8_we  = we_q[8];
    assign bus.w9_waddr  = waddr_q;  assign bus.w9_wdata  = wdata_q;  assign bus.w9_we  = we_q[9];
    assign bus.w10_waddr = waddr_q;  assign bus.w10_wdata = wdata_q;  assign bus.w10_we = we_q[10];
    assign bus.w11_waddr = waddr_q;  assign bus.w11_wdata = wdata_q;  assign bus.w11_we = we_q[11];
    assign bus.w12_waddr = waddr_q;  assign bus.w12_wdata = wdata_q;  assign bus.w12_we = we_q[12];
    assign bus.w13_waddr = waddr_q;  assign bus.w13_wdata = wdata_q;  assign bus.w13_we = we_q[13];
    assign bus.w14_waddr = waddr_q;  assign bus.w14_wdata = wdata_q;  assign bus.w14_we = we_q[14];
    assign bus.w15_waddr = waddr_q;  assign bus.w15_wdata = wdata_q;  assign bus.w15_we = we_q[15];

endmodule

// File: tb/tb_w7_loader.sv
// Directed bench for w7_loader: full loads with and without stalls, ignored start/valid,
// mid-load reset, and the checksum byte when W7_LOADER_CKSUM_EN is defined.
module tb_w7_loader;

    logic clk = 1'b0;
    logic xrst;

    w7_loader_if bus ();

    w7_loader dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-bank views of the write ports.
    logic [3:0]  waddr_a [16];
    logic [7:0]  wdata_a [16];
    logic [15:0] we_v;

    assign waddr_a[0]  = bus.w0_waddr;   assign wdata_a[0]  = bus.w0_wdata;
    assign waddr_a[1]  = bus.w1_waddr;   assign wdata_a[1]  = bus.w1_wdata;
    assign waddr_a[2]  = bus.w2_waddr;   assign wdata_a[2]  = bus.w2_wdata;
    assign waddr_a[3]  = bus.w3_waddr;   assign wdata_a[3]  = bus.w3_wdata;
    assign waddr_a[4]  = bus.w4_waddr;   assign wdata_a[4]  = bus.w4_wdata;
    assign waddr_a[5]  = bus.w5_waddr;   assign wdata_a[5]  = bus.w5_wdata;
    assign waddr_a[6]  = bus.w6_waddr;   assign wdata_a[6]  = bus.w6_wdata;
    assign waddr_a[7]  = bus.w7_waddr;   assign wdata_a[7]  = bus.w7_wdata;
    assign waddr_a[8]  = bus.w8_waddr;   assign wdata_a[8]  = bus.w8_wdata;
    assign waddr_a[9]  = bus.w9_waddr;   assign wdata_a[9]  = bus.w9_wdata;
    assign waddr_a[10] = bus.w10_waddr;  assign wdata_a[10] = bus.w10_wdata;
    assign waddr_a[11] = bus.w11_waddr;  assign wdata_a[11] = bus.w11_wdata;
    assign waddr_a[12] = bus.w12_waddr;  assign wdata_a[12] = bus.w12_wdata;
    assign waddr_a[13] = bus.w13_waddr;  assign wdata_a[13] = bus.w13_wdata;
    assign waddr_a[14] = bus.w14_waddr;  assign wdata_a[14] = bus.w14_wdata;
    assign waddr_a[15] = bus.w15_waddr;  assign wdata_a[15] = bus.w15_wdata;

    assign we_v = {bus.w15_we, bus.w14_we, bus.w13_we, bus.w12_we,
                   bus.w11_we, bus.w10_we, bus.w9_we,  bus.w8_we,
                   bus.w7_we,  bus.w6_we,  bus.w5_we,  bus.w4_we,
                   bus.w3_we,  bus.w2_we,  bus.w1_we,  bus.w0_we};

    // Bank memory model, filled from the write ports at each falling edge.
    int         cyc = 0;
    logic [7:0] mem [16][16];
    int         we_cnt [16];
    int         multi_we;
    int         fin_cnt;
    int         fin_cyc;
    logic       fin_ck;
    int         start_cyc;
    int         last_acc;

    always @(negedge clk) begin
        cyc++;
        if (!xrst) begin
            if ($countones(we_v) > 1) multi_we++;
            for (int b = 0; b < 16; b++) begin
                if (we_v[b]) begin
                    mem[b][waddr_a[b]] = wdata_a[b];
                    we_cnt[b]++;
                end
            end
            if (bus.finish) begin
                fin_cnt++;
                fin_cyc = cyc;
                fin_ck  = bus.cksum_err;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 16; b++) begin
            we_cnt[b] = 0;
            for (int a = 0; a < 16; a++) mem[b][a] = 8'h00;
        end
        multi_we = 0;
        fin_cnt  = 0;
        fin_cyc  = 0;
        fin_ck   = 1'b0;
    endtask

    function automatic int total_we();
        int t = 0;
        for (int b = 0; b < 16; b++) t += we_cnt[b];
        return t;
    endfunction

    task automatic do_start();
        bus.start = 1'b1;
        start_cyc = cyc + 1;
        tick();
        bus.start = 1'b0;
    endtask

    // Presents one byte, optionally after random idle cycles, and returns once it is accepted.
    task automatic send_byte(input logic [7:0] d, input bit stall);
        int budget = 64;
        if (stall) begin
            while ($urandom_range(0, 1) == 0) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!bus.in_ready) begin
            check("ready_wait", 32'(bus.in_ready), 32'd1);
        end else begin
            last_acc = cyc + 1;
            tick();
        end
    endtask

    task automatic wait_finish(input string tag);
        int budget = 16;
        while (fin_cnt == 0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (3) tick();
        check({tag, "_finish_count"}, 32'(fin_cnt), 32'd1);
        check({tag, "_finish_cycle"}, 32'(fin_cyc), 32'(last_acc + 2));
        check({tag, "_ready_after"},  32'(bus.in_ready), 32'd0);
    endtask

    // Stream k -> (flat ? ofs : k + ofs); checksum byte is the running sum plus ck_delta.
    task automatic send_stream(input int first, input int last, input logic [7:0] ofs,
                               input bit stall, input bit flat);
        for (int k = first; k <= last; k++) begin
            send_byte(flat ? ofs : 8'(k + int'(ofs)), stall);
        end
    endtask

    task automatic send_ck(input logic [7:0] ofs, input bit stall, input bit flat,
                           input logic [7:0] ck_delta);
`ifdef W7_LOADER_CKSUM_EN
        logic [7:0] s = 8'h00;
        for (int k = 0; k < 256; k++) s = s + (flat ? ofs : 8'(k + int'(ofs)));
        send_byte(s + ck_delta, stall);
`else
        if (ofs == 8'h00 && stall && flat && ck_delta == 8'h00) bus.in_valid = 1'b0;
`endif
        bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [7:0] ofs, input bit stall,
                            input bit flat, input logic [7:0] ck_delta);
        do_start();
        check({tag, "_ready_after_start"}, 32'(bus.in_ready), 32'd1);
        send_stream(0, 255, ofs, stall, flat);
        send_ck(ofs, stall, flat, ck_delta);
        wait_finish(tag);
    endtask

    task automatic check_banks(input string tag, input logic [7:0] ofs, input bit flat);
        for (int b = 0; b < 16; b++) begin
            check($sformatf("%s_we_count_b%0d", tag, b), 32'(we_cnt[b]), 32'd16);
            for (int a = 0; a < 16; a++) begin
                check($sformatf("%s_mem_b%0d_a%0d", tag, b, a), 32'(mem[b][a]),
                      32'(flat ? ofs : 8'(16 * a + b + int'(ofs))));
            end
        end
        check({tag, "_one_hot"}, 32'(multi_we), 32'd0);
    endtask

`ifdef W7_LOADER_CKSUM_EN
    localparam int MIN_LAT = 259;
`else
    localparam int MIN_LAT = 258;
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        xrst         = 1'b1;
        clear_model();
        repeat (3) tick();

        // Reset state
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_finish",    32'(bus.finish),    32'd0);
        check("rst_cksum_err", 32'(bus.cksum_err), 32'd0);
        check("rst_we",        32'(we_v),          32'd0);
        check("rst_waddr0",    32'(waddr_a[0]),    32'd0);
        check("rst_wdata15",   32'(wdata_a[15]),   32'd0);
        xrst = 1'b0;
        tick();
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // Full load, in_valid always high
        clear_model();
        run_load("full", 8'h00, 1'b0, 1'b0, 8'h00);
        check("full_latency", 32'(fin_cyc - start_cyc), 32'(MIN_LAT));
        check("full_cksum_err", 32'(fin_ck), 32'd0);
        check_banks("full", 8'h00, 1'b0);

        // Same stream with random stalls
        clear_model();
        run_load("stall", 8'h00, 1'b1, 1'b0, 8'h00);
        check_banks("stall", 8'h00, 1'b0);

        // Spurious valid in IDLE, then start pulsed during LOAD
        clear_model();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) tick();
        check("idle_valid_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        check("idle_valid_writes", 32'(total_we()), 32'd0);
        do_start();
        send_stream(0, 99, 8'h00, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        tick();
        check("start_in_load_writes", 32'(total_we()), 32'd100);
        send_stream(100, 255, 8'h00, 1'b0, 1'b0);
        send_ck(8'h00, 1'b0, 1'b0, 8'h00);
        wait_finish("ign");
        check_banks("ign", 8'h00, 1'b0);

        // Reset after 100 bytes
        clear_model();
        do_start();
        send_stream(0, 99, 8'h00, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        check("pre_rst_we", 32'(we_v), 32'h0008);
        xrst = 1'b1;
        #1;
        check("rst_mid_we",       32'(we_v),         32'd0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) tick();
        xrst = 1'b0;
        repeat (5) tick();
        check("rst_mid_finish",   32'(fin_cnt),      32'd0);
        check("rst_mid_writes",   32'(total_we()),   32'd99);
        check("rst_mid_mem_b2_a6", 32'(mem[2][6]),   32'd98);
        check("rst_mid_in_ready2", 32'(bus.in_ready), 32'd0);
        clear_model();
        run_load("reload", 8'h07, 1'b0, 1'b0, 8'h00);
        check_banks("reload", 8'h07, 1'b0);

`ifdef W7_LOADER_CKSUM_EN
        // Checksum: all 0x01 sums to 0x00
        clear_model();
        run_load("ck_ok", 8'h01, 1'b0, 1'b1, 8'h00);
        check("ck_ok_err", 32'(fin_ck), 32'd0);
        check_banks("ck_ok", 8'h01, 1'b1);
        clear_model();
        run_load("ck_bad", 8'h01, 1'b0, 1'b1, 8'h01);
        check("ck_bad_err_at_finish", 32'(fin_ck), 32'd1);
        check("ck_bad_err_held", 32'(bus.cksum_err), 32'd1);
        check_banks("ck_bad", 8'h01, 1'b1);
        do_start();
        check("ck_cleared_on_start", 32'(bus.cksum_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
